// File: rtl/spart.sv
// spart: bus-mapped 8N1 serial port with a programmable baud-rate generator
// and a 16x oversampled receiver, sitting on the CPU's shared 8-bit bus.
module spart #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  // state | meaning : IDLE line idle, START start bit, DATA 8 data bits, STOP stop bit
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic       rd_en, wr_en;
  logic [7:0] rdata;

  logic [15:0] div_q, div_d, brg_q, brg_d;
  logic        reload_q, reload_d, tick;

  logic [1:0] tx_st_q, tx_st_d;
  logic [7:0] tx_buf_q, tx_buf_d, tx_sh_q, tx_sh_d;
  logic [3:0] tx_tk_q, tx_tk_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       tbr_q, tbr_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rs;
  logic [1:0] rx_st_q, rx_st_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_buf_q, rx_buf_d;
  logic [3:0] rx_tk_q, rx_tk_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_done, rx_ferr;
  logic       rda_q, rda_d, ovr_q, ovr_d, ferr_q, ferr_d;

  assign rd_en = iocs & iorw;
  assign wr_en = iocs & ~iorw;

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00:   rdata = rx_buf_q;
      2'b01:   rdata = {4'b0000, ovr_q, ferr_q, tbr_q, rda_q};
      2'b10:   rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rdata : 8'hzz;

  // Divisor writes force a counter reload one cycle later so a new rate
  // applies without waiting for the old count to drain.
  assign tick = (brg_q == 16'd0);

  always_comb begin
    div_d    = div_q;
    reload_d = 1'b0;
    if (wr_en && ioaddr == 2'b10) begin
      div_d[7:0] = databus;
      reload_d   = 1'b1;
    end
    if (wr_en && ioaddr == 2'b11) begin
      div_d[15:8] = databus;
      reload_d    = 1'b1;
    end
    brg_d = (tick || reload_q) ? div_q : brg_q - 16'd1;
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_buf_d = tx_buf_q;
    tx_sh_d  = tx_sh_q;
    tx_tk_d  = tx_tk_q;
    tx_bit_d = tx_bit_q;
    tbr_d    = tbr_q;
    if (wr_en && ioaddr == 2'b00 && tbr_q) begin
      tx_buf_d = databus;
      tbr_d    = 1'b0;
    end
    case (tx_st_q)
      ST_IDLE: begin
        if (!tbr_q && tick) begin
          tx_sh_d = tx_buf_q;
          tx_tk_d = 4'd0;
          tx_st_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_tk_d = tx_tk_q + 4'd1;
          if (tx_tk_q == 4'd15) begin
            tx_bit_d = 3'd0;
            tx_st_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tx_tk_d = tx_tk_q + 4'd1;
          if (tx_tk_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              tx_st_d = ST_STOP;
            end else begin
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              tx_bit_d = tx_bit_q + 3'd1;
            end
          end
        end
      end
      default: begin
        if (tick) begin
          tx_tk_d = tx_tk_q + 4'd1;
          if (tx_tk_q == 4'd15) begin
            tx_st_d = ST_IDLE;
            tbr_d   = 1'b1;
          end
        end
      end
    endcase
  end

  assign txd = (tx_st_q == ST_START) ? 1'b0 :
               (tx_st_q == ST_DATA)  ? tx_sh_q[0] : 1'b1;
  assign tbr = tbr_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rs     = sync_q[SYNC_STAGES-1];

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_tk_d  = rx_tk_q;
    rx_bit_d = rx_bit_q;
    rx_done  = 1'b0;
    rx_ferr  = 1'b0;
    case (rx_st_q)
      ST_IDLE: begin
        if (!rs) begin
          rx_tk_d = 4'd0;
          rx_st_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          rx_tk_d = rx_tk_q + 4'd1;
          if (rx_tk_q == 4'd7) begin
            if (!rs) begin
              rx_tk_d  = 4'd0;
              rx_bit_d = 3'd0;
              rx_st_d  = ST_DATA;
            end else begin
              rx_st_d = ST_IDLE;
            end
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          rx_tk_d = rx_tk_q + 4'd1;
          if (rx_tk_q == 4'd15) begin
            rx_sh_d  = {rs, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = ST_STOP;
          end
        end
      end
      default: begin
        if (tick) begin
          rx_tk_d = rx_tk_q + 4'd1;
          if (rx_tk_q == 4'd15) begin
            rx_st_d = ST_IDLE;
            rx_done = rs;
            rx_ferr = ~rs;
          end
        end
      end
    endcase
  end

  // Flag sets are applied after read-clears so a coincident event wins.
  always_comb begin
    rx_buf_d = rx_done ? rx_sh_q : rx_buf_q;
    rda_d    = rda_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    if (rd_en && ioaddr == 2'b00) rda_d = 1'b0;
    if (rd_en && ioaddr == 2'b01) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (rx_done) rda_d = 1'b1;
    if (rx_done && rda_q) ovr_d = 1'b1;
    if (rx_ferr) ferr_d = 1'b1;
  end

  assign rda = rda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= DEFAULT_DIV;
      brg_q    <= DEFAULT_DIV;
      reload_q <= 1'b0;
      tx_st_q  <= ST_IDLE;
      tx_buf_q <= 8'h00;
      tx_sh_q  <= 8'h00;
      tx_tk_q  <= 4'd0;
      tx_bit_q <= 3'd0;
      tbr_q    <= 1'b1;
      sync_q   <= '1;
      rx_st_q  <= ST_IDLE;
      rx_sh_q  <= 8'h00;
      rx_tk_q  <= 4'd0;
      rx_bit_q <= 3'd0;
      rx_buf_q <= 8'h00;
      rda_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      brg_q    <= brg_d;
      reload_q <= reload_d;
      tx_st_q  <= tx_st_d;
      tx_buf_q <= tx_buf_d;
      tx_sh_q  <= tx_sh_d;
      tx_tk_q  <= tx_tk_d;
      tx_bit_q <= tx_bit_d;
      tbr_q    <= tbr_d;
      sync_q   <= sync_d;
      rx_st_q  <= rx_st_d;
      rx_sh_q  <= rx_sh_d;
      rx_tk_q  <= rx_tk_d;
      rx_bit_q <= rx_bit_d;
      rx_buf_q <= rx_buf_d;
      rda_q    <= rda_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: tb/tb_spart.sv
// Directed self-checking bench for spart: reset, divisor, transmit framing,
// loopback receive, glitch/framing errors, overrun and mid-frame reset.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tb_dout = 8'h00;
  logic       tb_drv = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  wire  [7:0] databus;
  wire        rxd_w;
  logic       rda, tbr, txd;

  int err_cnt = 0;
  int chk_cnt = 0;

  assign databus = tb_drv ? tb_dout : 8'hzz;
  assign rxd_w   = loop_en ? txd : rxd_drv;

  spart dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dout = d; tb_drv = 1'b1;
    cyc(1);
    iocs = 1'b0; iorw = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    d = databus;
    cyc(1);
    iocs = 1'b0;
  endtask

  // One 8N1 frame at 32 clk per bit; a zero stop bit is held only past its centre.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rxd_drv = 1'b0;
    cyc(32);
    for (int j = 0; j < 8; j++) begin
      rxd_drv = b[j];
      cyc(32);
    end
    rxd_drv = stop_v;
    cyc(stop_v ? 32 : 24);
    rxd_drv = 1'b1;
    cyc(64);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] tx_byte;
    int n;
    int lows;

    #2 rst = 1'b0;
    cyc(3);
    chk("rst_txd", 16'(txd), 16'd1);
    chk("rst_tbr", 16'(tbr), 16'd1);
    chk("rst_rda", 16'(rda), 16'd0);
    rst = 1'b1;
    cyc(1);
    bus_rd(2'b01, rd); chk("rst_status", 16'(rd), 16'h02);
    bus_rd(2'b10, rd); chk("rst_div_lo", 16'(rd), 16'h45);
    bus_rd(2'b11, rd); chk("rst_div_hi", 16'(rd), 16'h01);

    bus_wr(2'b10, 8'h01);
    bus_wr(2'b11, 8'h00);
    bus_rd(2'b10, rd); chk("div_lo", 16'(rd), 16'h01);
    bus_rd(2'b11, rd); chk("div_hi", 16'(rd), 16'h00);
    cyc(4);

    tx_byte = 8'hA5;
    bus_wr(2'b00, tx_byte);
    chk("tx_tbr_low", 16'(tbr), 16'd0);
    bus_wr(2'b00, 8'hFF);
    n = 0;
    while (txd && n < 200) begin cyc(1); n++; end
    chk("tx_start_seen", 16'(txd), 16'd0);
    n = 0;
    while (!txd && n < 100) begin cyc(1); n++; end
    chk("tx_start_len", 16'(n), 16'd32);
    cyc(16);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("tx_bit%0d", j), 16'(txd), 16'(tx_byte[j]));
      cyc(32);
    end
    chk("tx_stop", 16'(txd), 16'd1);
    chk("tx_tbr_in_stop", 16'(tbr), 16'd0);
    n = 0;
    while (!tbr && n < 100) begin cyc(1); n++; end
    chk("tx_tbr_ret_delay", 16'(n), 16'd16);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      if (!txd) lows++;
      cyc(1);
    end
    chk("tx_single_frame", 16'(lows), 16'd0);

    loop_en = 1'b1;
    bus_wr(2'b00, 8'h3C);
    n = 0;
    while (!rda && n < 1000) begin cyc(1); n++; end
    chk("lb_rda", 16'(rda), 16'd1);
    bus_rd(2'b00, rd); chk("lb_data", 16'(rd), 16'h3C);
    chk("lb_rda_clr", 16'(rda), 16'd0);
    cyc(50);
    loop_en = 1'b0;

    rxd_drv = 1'b0;
    cyc(8);
    rxd_drv = 1'b1;
    cyc(400);
    chk("glitch_rda", 16'(rda), 16'd0);
    bus_rd(2'b01, rd); chk("glitch_status", 16'(rd), 16'h02);

    send_frame(8'h55, 1'b0);
    chk("ferr_rda", 16'(rda), 16'd0);
    bus_rd(2'b01, rd); chk("ferr_status1", 16'(rd), 16'h06);
    bus_rd(2'b01, rd); chk("ferr_status2", 16'(rd), 16'h02);

    send_frame(8'h11, 1'b1);
    chk("ovr_first_rda", 16'(rda), 16'd1);
    send_frame(8'h22, 1'b1);
    bus_rd(2'b01, rd); chk("ovr_status1", 16'(rd), 16'h0B);
    bus_rd(2'b01, rd); chk("ovr_status2", 16'(rd), 16'h03);
    bus_rd(2'b00, rd); chk("ovr_data", 16'(rd), 16'h22);
    chk("ovr_rda_clr", 16'(rda), 16'd0);

    loop_en = 1'b1;
    bus_wr(2'b00, 8'h5A);
    cyc(100);
    chk("mid_txd_busy", 16'(tbr), 16'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_txd", 16'(txd), 16'd1);
    chk("mid_rst_tbr", 16'(tbr), 16'd1);
    chk("mid_rst_rda", 16'(rda), 16'd0);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    bus_rd(2'b01, rd); chk("mid_rst_status", 16'(rd), 16'h02);
    bus_rd(2'b10, rd); chk("mid_rst_div_lo", 16'(rd), 16'h45);
    bus_rd(2'b11, rd); chk("mid_rst_div_hi", 16'(rd), 16'h01);
    chk("mid_rst_txd_idle", 16'(txd), 16'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
